// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
//   Definitions shared by the serializer and the downstream Mealy/Moore
//   sequence detectors.
//   - seq_state_t      : two-state encoding (ST_IDLE = 0, ST_SHIFT = 1)
//   - IDLE_BIT_DEFAULT : line level driven while no word is being shifted
//   - cnt_width()      : counter width for an N-state bit counter (min 1 bit)
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_t;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // $clog2(1) is 0, so clamp to one bit to keep the counter declarable.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// -----------------------------------------------------------------------------
// seq_bit_counter
//   Bit position counter for one serialized word. Counts 0..N-1; the owner
//   clears it when a word is loaded and enables it while bits remain.
// Ports
//   clk   in  1   rising-edge clock
//   rst   in  1   asynchronous active-low reset (count -> 0)
//   clr   in  1   synchronous clear to 0 (wins over en)
//   en    in  1   increment by one
//   cnt   out CW  current count
//   last  out 1   cnt == N-1
// -----------------------------------------------------------------------------
module seq_bit_counter
  import seq_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign last = (cnt_reg == CW'(N - 1));

endmodule

// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//   Parallel-to-serial stage feeding the sequence detectors. Accepts WIDTH-bit
//   words over valid/ready and shifts them out one bit per clock, back to back
//   when the next word is offered in the last-bit cycle; otherwise the line
//   rests at IDLE_BIT.
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: din[WIDTH-1] leaves first, 0: din[0] leaves first
//   IDLE_BIT   ser_out level between words
// Ports
//   clk         in  1      rising-edge clock
//   rst         in  1      asynchronous active-low reset
//   din         in  WIDTH  parallel word, sampled on handshake
//   din_valid   in  1      upstream offers din
//   din_ready   out 1      word can be accepted at this edge
//   ser_out     out 1      serial bit (registered)
//   ser_valid   out 1      ser_out carries a word bit (registered)
//   busy        out 1      state is SHIFT (registered)
//   frame_done  out 1      last bit of the current word is on ser_out
// -----------------------------------------------------------------------------
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 4,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = cnt_width(WIDTH);

  seq_state_t       state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next, shifted;
  logic             ser_out_reg, ser_valid_reg, busy_reg;
  logic [CW-1:0]    cnt;
  logic             cnt_last, cnt_clr, cnt_en, accept;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  seq_bit_counter #(.N(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // Shift one position toward the head bit, filling the tail with zero.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (MSB_FIRST) begin : g_msb
        if (gi == 0) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi-1];
        end
      end else begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign shifted[gi] = 1'b0;
        end else begin : g_move
          assign shifted[gi] = shift_reg[gi+1];
        end
      end
    end
  endgenerate

  // Ready depends only on state and count so upstream can never form a
  // combinational loop through din_valid.
  assign din_ready = (state_reg == ST_IDLE) ||
                     ((state_reg == ST_SHIFT) && (cnt == CW'(WIDTH - 1)));
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          shift_next = din;
          cnt_clr    = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_last) begin
          if (accept) begin
            // Reload in the last-bit cycle: next word follows without a gap.
            shift_next = din;
            cnt_clr    = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          shift_next = shifted;
          cnt_en     = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they change only on
  // the clock edge and carry no decode glitches into the detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      ser_out_reg   <= IDLE_BIT;
      ser_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      ser_out_reg   <= (state_next == ST_SHIFT) ? head(shift_next) : IDLE_BIT;
      ser_valid_reg <= (state_next == ST_SHIFT);
      busy_reg      <= (state_next == ST_SHIFT);
    end
  end

  assign ser_out    = ser_out_reg;
  assign ser_valid  = ser_valid_reg;
  assign busy       = busy_reg;
  assign frame_done = (state_reg == ST_SHIFT) && cnt_last;

endmodule

// File: tb/tb_seq_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_serializer
//   Three serializer instances share din/din_valid:
//     0: MSB first, idle 0   1: LSB first, idle 0   2: MSB first, idle 1
//   Each has a reference model: a FIFO of bits still to appear on the line.
//   An accepted word appends its WIDTH bits in send order; every edge retires
//   the front bit. Ready means at most one bit is left.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_serializer;

  localparam int W  = 4;
  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  din = '0;
  logic          din_valid = 1'b0;
  logic [NI-1:0] din_ready, ser_out, ser_valid, busy, frame_done;

  initial begin
    #2;
    forever #5 clk = ~clk;
  end

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .busy(busy[0]), .frame_done(frame_done[0]));

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .busy(busy[1]), .frame_done(frame_done[1]));

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(din_ready[2]), .ser_out(ser_out[2]), .ser_valid(ser_valid[2]),
    .busy(busy[2]), .frame_done(frame_done[2]));

  // ---------------- reference model ----------------
  logic [63:0] mq     [NI];
  int          mcnt   [NI];
  logic [15:0] stream [NI];
  int          nvalid [NI];
  int          fdcnt  [NI];

  int checks = 0;
  int passes = 0;

  function automatic bit msb_of(input int j);
    return (j != 1);
  endfunction

  function automatic bit idle_of(input int j);
    return (j == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int j = 0; j < NI; j++) begin
      mq[j]   = '0;
      mcnt[j] = 0;
    end
  endtask

  task automatic stream_clear();
    for (int j = 0; j < NI; j++) begin
      stream[j] = '0;
      nvalid[j] = 0;
      fdcnt[j]  = 0;
    end
  endtask

  task automatic check_all(input string ph);
    for (int j = 0; j < NI; j++) begin
      chk($sformatf("%s.ready%0d", ph, j), 32'(din_ready[j]), 32'(mcnt[j] <= 1));
      chk($sformatf("%s.ser_out%0d", ph, j), 32'(ser_out[j]),
          32'((mcnt[j] > 0) ? mq[j][0] : idle_of(j)));
      chk($sformatf("%s.ser_valid%0d", ph, j), 32'(ser_valid[j]), 32'(mcnt[j] > 0));
      chk($sformatf("%s.busy%0d", ph, j), 32'(busy[j]), 32'(mcnt[j] > 0));
      chk($sformatf("%s.frame_done%0d", ph, j), 32'(frame_done[j]), 32'(mcnt[j] == 1));
    end
  endtask

  // Drive one clock cycle of stimulus (called shortly after an edge), advance
  // the model across the next rising edge and check all outputs after it.
  task automatic cycle(input string ph, input logic v, input logic [W-1:0] w);
    bit acc [NI];
    din_valid = v;
    din       = w;
    for (int j = 0; j < NI; j++) acc[j] = v && (mcnt[j] <= 1);
    @(posedge clk);
    #1;
    for (int j = 0; j < NI; j++) begin
      if (mcnt[j] > 0) begin
        mq[j] = mq[j] >> 1;
        mcnt[j]--;
      end
      if (acc[j]) begin
        for (int b = 0; b < W; b++)
          mq[j][mcnt[j] + b] = msb_of(j) ? w[W-1-b] : w[b];
        mcnt[j] += W;
      end
    end
    if (acc[0]) $display("%0t %s accept din=%b", $time, ph, w);
    check_all(ph);
    for (int j = 0; j < NI; j++) begin
      if (ser_valid[j]) begin
        stream[j] = {stream[j][14:0], ser_out[j]};
        nvalid[j]++;
      end
      if (frame_done[j]) fdcnt[j]++;
    end
  endtask

  task automatic idle_cycles(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 1'b0, W'($urandom));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    stream_clear();

    // Reset asserted from 1 ns to 5 ns; first rising edge at 7 ns.
    #1 rst = 1'b0;
    #2 check_all("in_reset");
    #2 rst = 1'b1;
    #1 check_all("post_reset");

    // Single word 1010, MSB first: 1,0,1,0 then idle.
    stream_clear();
    cycle("single", 1'b1, 4'b1010);
    idle_cycles("single", 5);
    chk("single.stream0", 32'(stream[0][3:0]), 32'h0000000a);
    chk("single.nvalid0", 32'(nvalid[0]), 32'd4);
    chk("single.fdcnt0", 32'(fdcnt[0]), 32'd1);

    // Back-to-back 1010, 0101 with din_valid held.
    stream_clear();
    cycle("b2b", 1'b1, 4'b1010);
    for (int i = 0; i < 4; i++) cycle("b2b", 1'b1, 4'b0101);
    idle_cycles("b2b", 6);
    chk("b2b.stream0", 32'(stream[0][7:0]), 32'h000000a5);
    chk("b2b.nvalid0", 32'(nvalid[0]), 32'd8);
    chk("b2b.fdcnt0", 32'(fdcnt[0]), 32'd2);

    // din scrambles while ready is low; only edge-0 and edge-4 words count.
    stream_clear();
    cycle("churn", 1'b1, 4'b1010);
    for (int i = 0; i < 3; i++) cycle("churn", 1'b1, W'($urandom));
    cycle("churn", 1'b1, 4'b0101);
    idle_cycles("churn", 6);
    chk("churn.stream0", 32'(stream[0][7:0]), 32'h000000a5);
    chk("churn.nvalid0", 32'(nvalid[0]), 32'd8);

    // LSB-first 0001 -> 1,0,0,0; idle-high instance rests at 1.
    stream_clear();
    cycle("lsb", 1'b1, 4'b0001);
    idle_cycles("lsb", 5);
    chk("lsb.stream1", 32'(stream[1][3:0]), 32'h00000008);
    chk("idle1.ser_out2", 32'(ser_out[2]), 32'd1);

    // Asynchronous reset in the middle of 1100.
    cycle("abort", 1'b1, 4'b1100);
    cycle("abort", 1'b0, 4'b0000);
    #2 rst = 1'b0;
    model_clear();
    #1 check_all("abort_rst");
    chk("abort.ser_out0", 32'(ser_out[0]), 32'd0);
    #2 rst = 1'b1;
    stream_clear();
    idle_cycles("after_abort", 6);
    chk("after_abort.nvalid0", 32'(nvalid[0]), 32'd0);

    // Randomized traffic, including gapless runs and idle gaps.
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 3) != 0), W'($urandom));
    idle_cycles("drain", 6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
